// File: rtl/gcd_pkg.sv
// Shared state type and default sizing for the GCD request-side driver.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } gcd_drv_state_t;

    localparam int GCD_WIDTH           = 10;
    localparam int GCD_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/gcd_wdog.sv
// Watchdog for the RUN phase: counts cycles while enabled and flags the last
// allowed cycle so the driver can abort a core that never finishes.
module gcd_wdog
    import gcd_pkg::*;
#(
    parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    assign hit = (count == LAST);

endmodule

// File: rtl/gcd_driver.sv
// Request-side controller for the GCD core: accepts operand pairs, runs the
// core under a watchdog, short-circuits zero operands and counts completions.
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_err,
    output logic [15:0]      done_count
);

    gcd_drv_state_t state;
    gcd_drv_state_t state_next;

    logic accept;
    logic a_zero;
    logic b_zero;
    logic wdog_hit;

    assign accept = (state == IDLE) && req_valid;
    assign a_zero = (req_a == '0);
    assign b_zero = (req_b == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A finishing core takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (a_zero || b_zero) ? RESP : RUN;
            RUN:     if (core_done || wdog_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        core_start = (state == RUN);
        rsp_valid  = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_a     <= '0;
            core_b     <= '0;
            rsp_res    <= '0;
            rsp_err    <= 1'b0;
            done_count <= '0;
        end else begin
            if (accept) begin
                core_a <= req_a;
                core_b <= req_b;
                if (a_zero || b_zero) begin
                    rsp_res <= a_zero ? req_b : req_a;
                    rsp_err <= a_zero && b_zero;
                end
            end
            if (state == RUN) begin
                if (core_done) begin
                    rsp_res <= core_res;
                    rsp_err <= 1'b0;
                end else if (wdog_hit) begin
                    rsp_res <= '0;
                    rsp_err <= 1'b1;
                end
            end
            if ((state == RESP) && rsp_ready) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

    gcd_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (state != RUN),
        .en   (state == RUN),
        .hit  (wdog_hit)
    );

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: a transaction-level model checks every cycle, while
// directed scenarios pin the model with hand-computed values.
module tb_gcd_driver;

    localparam int W  = 10;
    localparam int TO = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
    } stim_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         core_start;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_done;
    logic [W-1:0] core_res;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_res;
    logic         rsp_err;
    logic [15:0]  done_count;

    gcd_driver #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .core_start(core_start),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_done (core_done),
        .core_res  (core_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .done_count(done_count)
    );

    initial forever #5 clk = ~clk;

    int    tests_run    = 0;
    int    tests_failed = 0;
    stim_t stim[$];
    int    acc_cnt      = 0;
    bit    armed        = 0;
    int    preload_cnt  = 0;
    int    rsp_mode     = 0;

    // Model of the outstanding transaction: what it must produce and how long it runs.
    bit           busy      = 0;
    int           runs_exp  = 0;
    int           runs_seen = 0;
    int           m_lat     = 0;
    logic [W-1:0] m_a       = '0;
    logic [W-1:0] m_b       = '0;
    logic [W-1:0] m_res     = '0;
    logic         m_err     = 1'b0;
    logic [15:0]  m_count   = '0;
    int           preload_seen = 0;

    function automatic int gcd_ref(int x, int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        stim_t s;
        s.a   = a;
        s.b   = b;
        s.lat = lat;
        stim.push_back(s);
    endtask

    task automatic waitIdle(input int max_cycles);
        int n;
        bit idle;
        n    = 0;
        idle = 0;
        while (!idle && n < max_cycles) begin
            @(negedge clk);
            n++;
            idle = (acc_cnt == stim.size()) && !busy;
        end
        checkOutput("idle within bound", 32'(idle), 32'd1);
    endtask

    task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          output int starts, output logic [W-1:0] res,
                          output logic err, output int resp_lat);
        int n;
        bit accepted;
        bit seen;
        bit done;
        applyStimulus(a, b, lat);
        starts   = 0;
        resp_lat = -1;
        res      = 'x;
        err      = 1'bx;
        accepted = 0;
        seen     = 0;
        done     = 0;
        n        = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (core_start === 1'b1) starts++;
            if (accepted) resp_lat++;
            if (!accepted && req_valid && (req_ready === 1'b1)) begin
                accepted = 1;
                resp_lat = 0;
            end
            if (accepted && !seen && (rsp_valid === 1'b1)) begin
                seen = 1;
                res  = rsp_res;
                err  = rsp_err;
            end
            if (seen && (rsp_valid === 1'b1) && rsp_ready) done = 1;
        end
        checkOutput("transaction within bound", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    // Compare process: checks every cycle against the model, then advances it.
    initial begin
        bit exp_ready;
        bit exp_start;
        bit exp_rvalid;
        forever begin
            @(negedge clk);
            if (preload_seen != preload_cnt) begin
                preload_seen = preload_cnt;
                m_count      = 16'hFFFF;
            end
            exp_ready  = !busy;
            exp_start  = busy && (runs_seen < runs_exp);
            exp_rvalid = busy && (runs_seen == runs_exp);
            if (armed) begin
                checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
                checkOutput("core_start", 32'(core_start), 32'(exp_start));
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rvalid));
                checkOutput("done_count", 32'(done_count), 32'(m_count));
                if (exp_start) begin
                    checkOutput("core_a", 32'(core_a), 32'(m_a));
                    checkOutput("core_b", 32'(core_b), 32'(m_b));
                end
                if (exp_rvalid) begin
                    checkOutput("rsp_res", 32'(rsp_res), 32'(m_res));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
                end
            end
            if (reset === 1'b1) begin
                busy      = 0;
                runs_seen = 0;
                m_count   = '0;
            end else begin
                if (exp_start) runs_seen++;
                if (exp_rvalid && rsp_ready) begin
                    busy = 0;
                    m_count++;
                end
                if (exp_ready && req_valid && (acc_cnt < stim.size())) begin
                    m_a   = stim[acc_cnt].a;
                    m_b   = stim[acc_cnt].b;
                    m_lat = stim[acc_cnt].lat;
                    if (m_a == '0 || m_b == '0) begin
                        runs_exp = 0;
                        m_res    = (m_a == '0) ? m_b : m_a;
                        m_err    = (m_a == '0) && (m_b == '0);
                    end else if (m_lat <= TO) begin
                        runs_exp = m_lat;
                        m_res    = W'(gcd_ref(int'(m_a), int'(m_b)));
                        m_err    = 1'b0;
                    end else begin
                        runs_exp = TO;
                        m_res    = '0;
                        m_err    = 1'b1;
                    end
                    runs_seen = 0;
                    busy      = 1;
                    acc_cnt++;
                end
            end
        end
    end

    // Request driver: presents the oldest unaccepted pair until it is taken.
    initial begin
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_cnt < stim.size()) begin
                req_valid = 1'b1;
                req_a     = stim[acc_cnt].a;
                req_b     = stim[acc_cnt].b;
            end else begin
                req_valid = 1'b0;
                req_a     = W'($urandom);
                req_b     = W'($urandom);
            end
        end
    end

    // Core stand-in: finishes after the chosen latency, and throws stray done
    // pulses with junk results whenever it is not running.
    initial begin
        int cyc;
        cyc       = 0;
        core_done = 1'b0;
        core_res  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_start === 1'b1) begin
                cyc++;
                core_done = (cyc == m_lat);
                core_res  = core_done ? W'(gcd_ref(int'(m_a), int'(m_b))) : W'($urandom);
            end else begin
                cyc       = 0;
                core_done = ($urandom_range(0, 3) == 0);
                core_res  = W'($urandom);
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) == 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        int           starts;
        int           rlat;
        int           n;
        logic [W-1:0] res;
        logic         err;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1;
        @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset core_start", 32'(core_start), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_res", 32'(rsp_res), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset core_a", 32'(core_a), 32'd0);
        checkOutput("reset core_b", 32'(core_b), 32'd0);
        checkOutput("reset done_count", 32'(done_count), 32'd0);

        // Reset in the third RUN cycle abandons the job without counting it.
        applyStimulus(10'd20, 10'd30, 100);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((core_start !== 1'b1) && n < 50);
        checkOutput("run entered", 32'(core_start), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid-run reset core_start", 32'(core_start), 32'd0);
        checkOutput("mid-run reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid-run reset done_count", 32'(done_count), 32'd0);
        runOne(10'd12, 10'd8, 3, starts, res, err, rlat);
        checkOutput("12,8 result", 32'(res), 32'd4);
        checkOutput("12,8 err", 32'(err), 32'd0);
        checkOutput("12,8 start cycles", 32'(starts), 32'd3);

        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        runOne(10'd48, 10'd18, 5, starts, res, err, rlat);
        checkOutput("48,18 start cycles", 32'(starts), 32'd5);
        checkOutput("48,18 result", 32'(res), 32'd6);
        checkOutput("48,18 err", 32'(err), 32'd0);
        checkOutput("48,18 response latency", 32'(rlat), 32'd6);
        checkOutput("48,18 core_a", 32'(core_a), 32'd48);
        checkOutput("48,18 core_b", 32'(core_b), 32'd18);
        checkOutput("48,18 done_count", 32'(done_count), 32'd1);

        runOne(10'd0, 10'd35, 3, starts, res, err, rlat);
        checkOutput("0,35 start cycles", 32'(starts), 32'd0);
        checkOutput("0,35 result", 32'(res), 32'd35);
        checkOutput("0,35 err", 32'(err), 32'd0);
        checkOutput("0,35 response latency", 32'(rlat), 32'd1);

        runOne(10'd0, 10'd0, 3, starts, res, err, rlat);
        checkOutput("0,0 start cycles", 32'(starts), 32'd0);
        checkOutput("0,0 result", 32'(res), 32'd0);
        checkOutput("0,0 err", 32'(err), 32'd1);

        runOne(10'd21, 10'd14, 100, starts, res, err, rlat);
        checkOutput("timeout start cycles", 32'(starts), 32'd8);
        checkOutput("timeout result", 32'(res), 32'd0);
        checkOutput("timeout err", 32'(err), 32'd1);
        checkOutput("timeout response latency", 32'(rlat), 32'd9);

        runOne(10'd21, 10'd14, 8, starts, res, err, rlat);
        checkOutput("done-at-limit start cycles", 32'(starts), 32'd8);
        checkOutput("done-at-limit result", 32'(res), 32'd7);
        checkOutput("done-at-limit err", 32'(err), 32'd0);

        // Backpressure with a second request waiting behind the held response.
        rsp_mode = 2;
        applyStimulus(10'd9, 10'd6, 2);
        applyStimulus(10'd0, 10'd7, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rsp_valid !== 1'b1) && n < 50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held req_ready", 32'(req_ready), 32'd0);
            checkOutput("held rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("held rsp_res", 32'(rsp_res), 32'd3);
            checkOutput("held rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("held req_valid", 32'(req_valid), 32'd1);
        end
        rsp_mode = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("release req_ready", 32'(req_ready), 32'd1);
        checkOutput("release req_valid", 32'(req_valid), 32'd1);
        @(negedge clk);
        checkOutput("second rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("second rsp_res", 32'(rsp_res), 32'd7);
        waitIdle(50);

        // Random traffic with random response backpressure.
        rsp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 1023));
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 1023));
            applyStimulus(ra, rb, $urandom_range(1, 12));
        end
        waitIdle(5000);
        @(negedge clk);
        rsp_mode = 0;
        repeat (2) @(negedge clk);

        // Jump the completion counter to its last value, then wrap it.
        @(posedge clk);
        #1;
        force dut.done_count = 16'hFFFF;
        preload_cnt++;
        #2;
        release dut.done_count;
        @(negedge clk);
        checkOutput("preloaded done_count", 32'(done_count), 32'd65535);
        runOne(10'd0, 10'd5, 1, starts, res, err, rlat);
        checkOutput("wrapped done_count", 32'(done_count), 32'd0);
        checkOutput("wrap result", 32'(res), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gcd_driver.md
# gcd_driver

Request-side controller for the GCD engine, at the other end of its start/finish handshake. Accepts operand pairs over a valid/ready request port and drives the GCD core's `start`, operand and done/result interface. Returns each result on a valid/ready response port. Adds three things the core lacks: zero-operand bypass, a watchdog timeout and a completion counter, so upstream logic never has to sequence the core directly.

## Interface
Parameters:
- `WIDTH`, 10: operand/result width; matches the GCD datapath.
- `TIMEOUT`, 1023: maximum cycles spent in RUN before aborting; legal range 1 to 2^16-1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `req_valid`  in  1  operand pair offered.
- `req_ready`  out  1  driver can accept a pair.
- `req_a`, `req_b`  in  WIDTH  operands.
- `core_start`  out  1  level start to the GCD core.
- `core_a`, `core_b`  out  WIDTH  registered operands to the core.
- `core_done`  in  1  core finish indication.
- `core_res`  in  WIDTH  core result; valid when `core_done`=1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_res`  out  WIDTH  GCD result.
- `rsp_err`  out  1  1 = timeout or gcd(0,0).
- `done_count`  out  16  number of responses consumed; wraps.

## Operation
- States: IDLE, RUN, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture `req_a` and `req_b` into the operand registers.
  - If both operands are nonzero, go to RUN.
  - Otherwise go to RESP with a bypass result:
    - gcd(0,b)=b, `err`=0
    - gcd(a,0)=a, `err`=0
    - gcd(0,0)=0, `err`=1
- RUN:
  - `core_start`=1. `core_a` and `core_b` are held stable.
  - The watchdog counter clears on entry and increments each cycle.
  - If `core_done`=1: capture `core_res`, set `err`=0, go to RESP.
  - Else, if the count equals TIMEOUT-1: set res=0, `err`=1, go to RESP.
  - `core_done` and timeout in the same cycle: `core_done` wins.
- RESP:
  - `rsp_valid`=1. `rsp_res` and `rsp_err` are stable until accepted.
  - On `rsp_ready`: increment `done_count` (wraps from 0xFFFF to 0), go to IDLE.
- `core_done` is ignored outside RUN.
- `req_valid` is ignored outside IDLE. Requests are never dropped, only stalled.
- All outputs come from registers or state decode; no combinational path from inputs to outputs.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `core_start`=0, `core_a`/`core_b`=0, `rsp_valid`=0, `rsp_res`=0, `rsp_err`=0, `done_count`=0, watchdog=0.
- Reset while in RUN or RESP: the next edge with `reset`=1 forces IDLE.
  - `core_start` drops in that cycle.
  - A pending response is discarded and not counted.
- Request accepted at edge T:
  - Nonzero operands: `core_start`=1 from T+1.
  - Zero operand: `rsp_valid`=1 from T+1.
- `core_done` sampled high at edge D: `core_start`=0 and `rsp_valid`=1 from D+1.
- Timeout: the abort edge is the TIMEOUT-th edge in RUN, so RUN lasts exactly TIMEOUT cycles.
- Response accepted at edge R: IDLE with `req_ready`=1 from R+1; `done_count` updated at R+1.
- Minimum spacing between accepted requests: 2 cycles (bypass), 3 cycles (core path with done after 1 cycle).

## Structure
- Package `gcd_pkg`:
  - state enum `gcd_drv_state_t` {IDLE, RUN, RESP}
  - `GCD_WIDTH`=10
  - `GCD_TIMEOUT_DEFAULT`=1023
- Sub-module `gcd_wdog`:
  - 16-bit counter with `clr`, `en` and a `hit` output (count == TIMEOUT-1).
  - Same `clk`/`reset` convention.
- Top-level FSM and datapath registers stay in `gcd_driver`.

## Test plan
- Reset, then a=48, b=18. Core model asserts `core_done` with res=6 after 5 RUN cycles.
  - Expect `core_start` high for exactly 5 cycles, `core_a`=48, `core_b`=18.
  - Expect `rsp_res`=6, `rsp_err`=0, `done_count`=1.
- Bypass cases, each with `core_start` never asserted:
  - a=0, b=35: response 35, err=0, at T+1.
  - a=0, b=0: response 0, err=1.
- TIMEOUT=8, core never asserts done.
  - Expect `core_start` high for exactly 8 cycles.
  - Expect `rsp_res`=0, `rsp_err`=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles with a second `req_valid` pending.
  - Expect `req_ready`=0 and the response held stable.
  - After release, the second request is accepted on the cycle after the handshake.
- Assert `reset` in the 3rd RUN cycle.
  - Expect `core_start`=0 and `rsp_valid`=0 from the next cycle, `done_count` unchanged.
  - A subsequent a=12, b=8 then completes with 4.
- Preload 65535 completions (force or loop).
  - One more accepted response wraps `done_count` to 0.
